cpu_datapath: RTL and testbench



---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/cpu_datapath_alu.sv | 102 ++++++++++
 rtl/cpu_datapath.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_datapath.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the single-bus CPU datapath.
//                Holds the ALU opcode values and the bus-source select
//                encoding that is used by the bus encoder and bus multiplexer.
//  Contents    : opcode_t / OP_* ALU opcodes
//                bus_sel_t / SEL_* bus source codes, SRC_COUNT
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // ALU opcode encoding
    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_SHR  = 5'b00101;
    localparam opcode_t OP_SHRA = 5'b00110;
    localparam opcode_t OP_SHL  = 5'b00111;
    localparam opcode_t OP_ROR  = 5'b01000;
    localparam opcode_t OP_ROL  = 5'b01001;
    localparam opcode_t OP_AND  = 5'b01010;
    localparam opcode_t OP_OR   = 5'b01011;
    localparam opcode_t OP_MUL  = 5'b01110;
    localparam opcode_t OP_DIV  = 5'b01111;
    localparam opcode_t OP_NEG  = 5'b10000;
    localparam opcode_t OP_NOT  = 5'b10001;

    // Bus source select. Codes 0..15 select GPR R0..R15 directly; the
    // remaining sources follow in descending priority order, so a lower
    // code always means a higher bus priority.
    localparam int SEL_W = 5;
    typedef logic [SEL_W-1:0] bus_sel_t;

    localparam bus_sel_t SEL_HI     = 5'd16;
    localparam bus_sel_t SEL_LO     = 5'd17;
    localparam bus_sel_t SEL_ZHIGH  = 5'd18;
    localparam bus_sel_t SEL_ZLOW   = 5'd19;
    localparam bus_sel_t SEL_PC     = 5'd20;
    localparam bus_sel_t SEL_MDR    = 5'd21;
    localparam bus_sel_t SEL_INPORT = 5'd22;
    localparam bus_sel_t SEL_NONE   = 5'd31;

    // Number of bus sources (16 GPRs + 7 special registers)
    localparam int SRC_COUNT = 23;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_datapath_alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational ALU for the single-bus datapath. Operand A
//                comes from the Y register, operand B from the bus. The
//                result is 2*WIDTH bits wide; only MUL and DIV use the upper
//                half, every other operation zero-extends.
//  Ports       : a      in  WIDTH     operand A (Y register)
//                b      in  WIDTH     operand B (bus)
//                opcode in  5         ALU operation
//                result out 2*WIDTH   result, captured into Z
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [4:0]         opcode,
    output logic [2*WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [SHW:0]     C_WIDTH_SH = WIDTH[SHW:0];
    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    // Shift / rotate amount and its complement for the rotate halves.
    // A complement of WIDTH makes the wrapped half shift out to zero,
    // so a rotate by 0 returns the operand unchanged.
    logic [SHW-1:0] w_sh;
    logic [SHW:0]   w_sh_inv;
    logic [WIDTH-1:0] w_shra;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_rol;

    assign w_sh     = b[SHW-1:0];
    assign w_sh_inv = C_WIDTH_SH - {1'b0, w_sh};
    assign w_shra   = $signed(a) >>> w_sh;
    assign w_ror    = (a >> w_sh) | (a << w_sh_inv);
    assign w_rol    = (a << w_sh) | (a >> w_sh_inv);

    // Signed multiply on operands sign-extended to the full product width
    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_prod;

    assign w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed divide. Divide-by-zero and MIN/-1 overflow are produced by
    // explicit muxing; the divider itself is handed a divisor of 1 in those
    // cases so it never sees an undefined operand pair.
    logic                    w_div_zero;
    logic                    w_div_ovf;
    logic signed [WIDTH-1:0] w_div_a;
    logic signed [WIDTH-1:0] w_div_b;
    logic signed [WIDTH-1:0] w_quot;
    logic signed [WIDTH-1:0] w_rem;

    assign w_div_zero = (b == '0);
    assign w_div_ovf  = (a == C_MIN_NEG) && (b == C_ALL_ONES);
    assign w_div_a    = a;
    assign w_div_b    = (w_div_zero || w_div_ovf) ? C_ONE : b;
    assign w_quot     = w_div_a / w_div_b;   // truncates toward zero
    assign w_rem      = w_div_a % w_div_b;   // sign follows the dividend

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = {{WIDTH{1'b0}}, a + b};
            OP_SUB:  result = {{WIDTH{1'b0}}, a - b};
            OP_SHR:  result = {{WIDTH{1'b0}}, a >> w_sh};
            OP_SHRA: result = {{WIDTH{1'b0}}, w_shra};
            OP_SHL:  result = {{WIDTH{1'b0}}, a << w_sh};
            OP_ROR:  result = {{WIDTH{1'b0}}, w_ror};
            OP_ROL:  result = {{WIDTH{1'b0}}, w_rol};
            OP_AND:  result = {{WIDTH{1'b0}}, a & b};
            OP_OR:   result = {{WIDTH{1'b0}}, a | b};
            OP_MUL:  result = w_prod;
            OP_DIV: begin
                if (w_div_zero) begin
                    result = {a, C_ALL_ONES};
                end else if (w_div_ovf) begin
                    result = {{WIDTH{1'b0}}, C_MIN_NEG};
                end else begin
                    result = {w_rem, w_quot};
                end
            end
            OP_NEG:  result = {{WIDTH{1'b0}}, {WIDTH{1'b0}} - b};
            OP_NOT:  result = {{WIDTH{1'b0}}, ~b};
            default: result = '0;
        endcase
    end

endmodule : alu
`default_nettype wire

// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_datapath
//  Description : 32-bit single-bus CPU datapath. Sixteen GPRs plus PC, IR,
//                HI, LO, Y, Z (2*WIDTH), MAR, MDR and an input-port register
//                share one bus. A fixed-priority encoder picks the bus
//                source; the ALU combines Y with the bus into Z.
//  Ports       : clock, clear            clock and synchronous reset
//                R0in..R15in, PCin, HIin, LOin, Yin, MARin, InPortIn, IRin,
//                Zin, MDRin, incPC       register load strobes
//                read                    MDR source: 1 = Mdatain, 0 = bus
//                opcode                  ALU operation
//                Mdatain, in_port_data   memory / input-port data
//                R0out..R15out, HIout, LOout, ZHighOut, ZLowOut, PCout,
//                MDRout, InPortOut       bus drive strobes
//                bus_out                 current bus value
//                mar_q, pc_q, ir_q, hi_q, lo_q, z_q   register observation
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16   // port list carries exactly 16 GPR strobes
) (
    input  logic               clock,
    input  logic               clear,
    // GPR load strobes
    input  logic R0in,  input logic R1in,  input logic R2in,  input logic R3in,
    input  logic R4in,  input logic R5in,  input logic R6in,  input logic R7in,
    input  logic R8in,  input logic R9in,  input logic R10in, input logic R11in,
    input  logic R12in, input logic R13in, input logic R14in, input logic R15in,
    // special register load strobes
    input  logic               PCin,
    input  logic               HIin,
    input  logic               LOin,
    input  logic               Yin,
    input  logic               MARin,
    input  logic               InPortIn,
    input  logic               Zin,
    input  logic               IRin,
    input  logic               incPC,
    input  logic               MDRin,
    input  logic               read,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   Mdatain,
    input  logic [WIDTH-1:0]   in_port_data,
    // GPR bus drive strobes
    input  logic R0out,  input logic R1out,  input logic R2out,  input logic R3out,
    input  logic R4out,  input logic R5out,  input logic R6out,  input logic R7out,
    input  logic R8out,  input logic R9out,  input logic R10out, input logic R11out,
    input  logic R12out, input logic R13out, input logic R14out, input logic R15out,
    // special register bus drive strobes
    input  logic               PCout,
    input  logic               HIout,
    input  logic               LOout,
    input  logic               ZHighOut,
    input  logic               ZLowOut,
    input  logic               MDRout,
    input  logic               InPortOut,
    // observation
    output logic [WIDTH-1:0]   bus_out,
    output logic [WIDTH-1:0]   mar_q,
    output logic [WIDTH-1:0]   pc_q,
    output logic [WIDTH-1:0]   ir_q,
    output logic [WIDTH-1:0]   hi_q,
    output logic [WIDTH-1:0]   lo_q,
    output logic [2*WIDTH-1:0] z_q
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam int               GPR_IDX_W = $clog2(NREGS);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   r_gpr [NREGS];
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_ir;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_y;
    logic [2*WIDTH-1:0] r_z;
    logic [WIDTH-1:0]   r_mar;
    logic [WIDTH-1:0]   r_mdr;
    logic [WIDTH-1:0]   r_inport;

    // ------------------------------------------------------------------
    // Strobe vectors
    // ------------------------------------------------------------------
    logic [NREGS-1:0]     w_rin;
    logic [SRC_COUNT-1:0] w_out;   // bit index == bus select code

    assign w_rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

    assign w_out = {InPortOut, MDRout, PCout, ZLowOut, ZHighOut, LOout, HIout,
                    R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // ------------------------------------------------------------------
    // Bus encoder: scanning from the lowest-priority source upward lets the
    // highest-priority active strobe overwrite the selection last.
    // ------------------------------------------------------------------
    bus_sel_t w_sel;

    always_comb begin
        w_sel = SEL_NONE;
        for (int i = SRC_COUNT - 1; i >= 0; i--) begin
            if (w_out[i]) begin
                w_sel = SEL_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus multiplexer
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_bus;

    always_comb begin
        w_bus = '0;
        case (w_sel)
            SEL_HI:     w_bus = r_hi;
            SEL_LO:     w_bus = r_lo;
            SEL_ZHIGH:  w_bus = r_z[2*WIDTH-1:WIDTH];
            SEL_ZLOW:   w_bus = r_z[WIDTH-1:0];
            SEL_PC:     w_bus = r_pc;
            SEL_MDR:    w_bus = r_mdr;
            SEL_INPORT: w_bus = r_inport;
            SEL_NONE:   w_bus = '0;
            default: begin
                // codes below 16 address a GPR directly
                if (!w_sel[SEL_W-1]) begin
                    w_bus = r_gpr[w_sel[GPR_IDX_W-1:0]];
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU and MDR input mux
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_alu_result;
    logic [WIDTH-1:0]   w_mdr_d;

    alu #(
        .WIDTH  (WIDTH)
    ) u_alu (
        .a      (r_y),
        .b      (w_bus),
        .opcode (opcode),
        .result (w_alu_result)
    );

    assign w_mdr_d = read ? Mdatain : w_bus;

    // ------------------------------------------------------------------
    // Register file and special registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_rin[i]) begin
                    r_gpr[i] <= w_bus;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_mar    <= '0;
            r_mdr    <= '0;
            r_inport <= '0;
        end else begin
            // an explicit PC load wins over increment
            if (PCin) begin
                r_pc <= w_bus;
            end else if (incPC) begin
                r_pc <= r_pc + C_ONE;
            end
            if (IRin)     r_ir     <= w_bus;
            if (HIin)     r_hi     <= w_bus;
            if (LOin)     r_lo     <= w_bus;
            if (Yin)      r_y      <= w_bus;
            if (Zin)      r_z      <= w_alu_result;
            if (MARin)    r_mar    <= w_bus;
            if (MDRin)    r_mdr    <= w_mdr_d;
            if (InPortIn) r_inport <= in_port_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_out = w_bus;
    assign mar_q   = r_mar;
    assign pc_q    = r_pc;
    assign ir_q    = r_ir;
    assign hi_q    = r_hi;
    assign lo_q    = r_lo;
    assign z_q     = r_z;

endmodule : cpu_datapath
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_datapath
//  Description : Self-checking bench for cpu_datapath. Directed steps from
//                the test plan followed by randomized ALU operations and
//                randomized bus-priority patterns, compared against a
//                behavioural model kept in this file.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_datapath;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    logic [15:0] rin, rout;
    logic        PCin, HIin, LOin, Yin, MARin, InPortIn, Zin, IRin, incPC, MDRin, read;
    logic [4:0]  opcode;
    logic [31:0] Mdatain, in_port_data;
    logic        PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut;
    logic [31:0] bus_out, mar_q, pc_q, ir_q, hi_q, lo_q;
    logic [63:0] z_q;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // behavioural model state
    logic [31:0] m_gpr [16];
    logic [31:0] m_hi, m_lo, m_pc, m_mdr, m_inport;
    logic [63:0] m_z;

    cpu_datapath dut (
        .clock(clock), .clear(clear),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .PCin(PCin), .HIin(HIin), .LOin(LOin), .Yin(Yin), .MARin(MARin),
        .InPortIn(InPortIn), .Zin(Zin), .IRin(IRin), .incPC(incPC),
        .MDRin(MDRin), .read(read), .opcode(opcode),
        .Mdatain(Mdatain), .in_port_data(in_port_data),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighOut(ZHighOut),
        .ZLowOut(ZLowOut), .MDRout(MDRout), .InPortOut(InPortOut),
        .bus_out(bus_out), .mar_q(mar_q), .pc_q(pc_q), .ir_q(ir_q),
        .hi_q(hi_q), .lo_q(lo_q), .z_q(z_q)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rin = '0; rout = '0;
        PCin = 0; HIin = 0; LOin = 0; Yin = 0; MARin = 0; InPortIn = 0;
        Zin = 0; IRin = 0; incPC = 0; MDRin = 0; read = 0; opcode = '0;
        PCout = 0; HIout = 0; LOout = 0; ZHighOut = 0; ZLowOut = 0;
        MDRout = 0; InPortOut = 0;
    endtask

    // one clock edge, then release all strobes 1 ns later
    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    // reference ALU written from the operation definitions
    function automatic logic [63:0] ref_alu(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned n;
        logic [63:0] dbl;
        logic [31:0] ma, mb, qm, rm, q, r;
        n = b[4:0];
        case (op)
            OP_ADD:  return {32'd0, a + b};
            OP_SUB:  return {32'd0, a - b};
            OP_SHR:  return {32'd0, a >> n};
            OP_SHRA: return {32'd0, 32'($signed(a) >>> n)};
            OP_SHL:  return {32'd0, a << n};
            OP_ROR: begin
                dbl = {a, a} >> n;
                return {32'd0, dbl[31:0]};
            end
            OP_ROL: begin
                dbl = {a, a} << n;
                return {32'd0, dbl[63:32]};
            end
            OP_AND:  return {32'd0, a & b};
            OP_OR:   return {32'd0, a | b};
            OP_MUL:  return 64'(longint'($signed(a)) * longint'($signed(b)));
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ma = a[31] ? (32'd0 - a) : a;
                mb = b[31] ? (32'd0 - b) : b;
                qm = ma / mb;
                rm = ma % mb;
                q  = (a[31] ^ b[31]) ? (32'd0 - qm) : qm;
                r  = a[31] ? (32'd0 - rm) : rm;
                return {r, q};
            end
            OP_NEG:  return {32'd0, 32'd0 - b};
            OP_NOT:  return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic mdr_load(input logic [31:0] v);
        Mdatain = v; read = 1; MDRin = 1;
        tick();
        m_mdr = v;
    endtask

    task automatic gpr_load(input int i, input logic [31:0] v);
        mdr_load(v);
        MDRout = 1; rin[i] = 1;
        #1 check("bus_mdr", {32'd0, bus_out}, {32'd0, v});
        tick();
        m_gpr[i] = v;
    endtask

    // Y <= a, then Z <= ALU(op, Y, b)
    task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        mdr_load(a);
        MDRout = 1; Yin = 1;
        tick();
        mdr_load(b);
        MDRout = 1; opcode = op; Zin = 1;
        tick();
        m_z = ref_alu(op, a, b);
    endtask

    logic [4:0]  ops [14];
    logic [4:0]  op;
    logic [31:0] ra, rb, exp_bus;
    logic [31:0] src [23];
    logic [22:0] mask;

    initial begin
        ops = '{OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
                OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT, 5'b00000};
        idle();
        Mdatain = '0; in_port_data = '0;
        clear = 1;
        repeat (2) @(posedge clock);
        #1 clear = 0;

        // ---------------- power-on reset ----------------
        check("rst_pc",  {32'd0, pc_q},  64'd0);
        check("rst_z",   z_q,            64'd0);
        check("rst_bus", {32'd0, bus_out}, 64'd0);

        // ---------------- MDR loads into R2 / R6 ----------------
        gpr_load(2, 32'hFFFF_FFFB);
        gpr_load(6, 32'd25);

        // ---------------- DIV R2 / R6 ----------------
        rout[2] = 1; Yin = 1; tick();
        rout[6] = 1; opcode = OP_DIV; Zin = 1; tick();
        check("div_z", z_q, {32'hFFFF_FFFB, 32'h0000_0000});
        m_z = {32'hFFFF_FFFB, 32'h0000_0000};
        ZLowOut = 1; LOin = 1; tick();
        check("div_lo", {32'd0, lo_q}, 64'd0);
        ZHighOut = 1; HIin = 1; tick();
        check("div_hi", {32'd0, hi_q}, {32'd0, 32'hFFFF_FFFB});
        m_lo = 32'd0; m_hi = 32'hFFFF_FFFB;

        // ---------------- directed ALU cases ----------------
        alu_run(OP_MUL, 32'hFFFF_FFFD, 32'd7);
        check("mul", z_q, 64'hFFFF_FFFF_FFFF_FFEB);
        alu_run(OP_DIV, 32'd9, 32'd0);
        check("div0", z_q, {32'd9, 32'hFFFF_FFFF});
        alu_run(OP_ADD, 32'd30, 32'd25);
        check("add", z_q, 64'd55);
        alu_run(OP_SHRA, 32'h8000_0000, 32'd1);
        check("shra", z_q, 64'h0000_0000_C000_0000);
        alu_run(OP_ROR, 32'h8000_0000, 32'd1);
        check("ror", z_q, 64'h0000_0000_4000_0000);
        alu_run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf", z_q, 64'h0000_0000_8000_0000);
        alu_run(OP_DIV, 32'hFFFF_FFF9, 32'd2);     // -7 / 2 = -3 rem -1
        check("div_neg", z_q, 64'hFFFF_FFFF_FFFF_FFFD);
        alu_run(5'b11111, 32'h1234_5678, 32'h9ABC_DEF0);
        check("bad_op", z_q, 64'd0);

        // ---------------- PC ----------------
        mdr_load(32'hFFFF_FFFF);
        MDRout = 1; PCin = 1; tick();
        check("pc_load", {32'd0, pc_q}, {32'd0, 32'hFFFF_FFFF});
        incPC = 1; tick();
        check("pc_wrap", {32'd0, pc_q}, 64'd0);
        incPC = 1; tick();
        check("pc_inc", {32'd0, pc_q}, 64'd1);
        mdr_load(32'h0000_1234);
        MDRout = 1; PCin = 1; incPC = 1; tick();
        check("pc_prio", {32'd0, pc_q}, 64'h1234);
        m_pc = 32'h0000_1234;

        // ---------------- bus priority / idle bus ----------------
        gpr_load(3, 32'hA5A5_0003);
        gpr_load(5, 32'h5A5A_0005);
        rout[3] = 1; rout[5] = 1;
        #1 check("prio_r3_r5", {32'd0, bus_out}, {32'd0, 32'hA5A5_0003});
        idle();
        #1 check("bus_idle", {32'd0, bus_out}, 64'd0);

        // ---------------- input port, MAR, IR, MDR from bus ----------------
        in_port_data = $urandom;
        InPortIn = 1; tick();
        m_inport = in_port_data;
        in_port_data = ~m_inport;
        InPortOut = 1; MARin = 1; IRin = 1;
        #1 check("bus_inport", {32'd0, bus_out}, {32'd0, m_inport});
        tick();
        check("mar", {32'd0, mar_q}, {32'd0, m_inport});
        check("ir",  {32'd0, ir_q},  {32'd0, m_inport});
        rout[5] = 1; MDRin = 1; read = 0; Mdatain = ~m_gpr[5]; tick();
        m_mdr = m_gpr[5];
        MDRout = 1;
        #1 check("mdr_from_bus", {32'd0, bus_out}, {32'd0, m_mdr});
        idle();

        // ---------------- randomized ALU against the model ----------------
        for (int k = 0; k < 40; k++) begin
            op = (k % 5 == 4) ? 5'($urandom) : ops[$urandom_range(0, 13)];
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(0, 40);
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            alu_run(op, ra, rb);
            check($sformatf("alu_rand op=%b a=%h b=%h", op, ra, rb), z_q, m_z);
            if (k % 3 == 0) begin
                ZHighOut = 1; HIin = 1; tick();
                ZLowOut = 1; LOin = 1; tick();
                m_hi = m_z[63:32]; m_lo = m_z[31:0];
                check("hi_from_z", {32'd0, hi_q}, {32'd0, m_hi});
                check("lo_from_z", {32'd0, lo_q}, {32'd0, m_lo});
            end
        end

        // ---------------- randomized bus priority ----------------
        for (int i = 0; i < 16; i++) gpr_load(i, $urandom);
        for (int i = 0; i < 16; i++) src[i] = m_gpr[i];
        src[16] = m_hi;        src[17] = m_lo;
        src[18] = m_z[63:32];  src[19] = m_z[31:0];
        src[20] = m_pc;        src[21] = m_mdr;   src[22] = m_inport;
        for (int k = 0; k < 24; k++) begin
            mask = 23'($urandom & $urandom & $urandom);
            if (k < 7) mask = 23'(1) << (16 + k);   // each special source alone
            @(negedge clock);
            rout = mask[15:0];
            HIout = mask[16]; LOout = mask[17]; ZHighOut = mask[18]; ZLowOut = mask[19];
            PCout = mask[20]; MDRout = mask[21]; InPortOut = mask[22];
            exp_bus = 32'd0;
            for (int s = 0; s < 23; s++) begin
                if (mask[s]) begin
                    exp_bus = src[s];
                    break;
                end
            end
            #1 check($sformatf("bus_prio mask=%h", mask), {32'd0, bus_out}, {32'd0, exp_bus});
            idle();
        end

        // ---------------- reset mid-sequence beats every load ----------------
        @(negedge clock);
        rin = '1; PCin = 1; incPC = 1; HIin = 1; LOin = 1; Yin = 1; MARin = 1;
        IRin = 1; InPortIn = 1; Zin = 1; MDRin = 1; read = 1; opcode = OP_ADD;
        Mdatain = 32'hDEAD_BEEF; in_port_data = 32'hCAFE_F00D; MDRout = 1;
        clear = 1;
        tick();
        clear = 0;
        check("clr_pc",  {32'd0, pc_q},  64'd0);
        check("clr_ir",  {32'd0, ir_q},  64'd0);
        check("clr_hi",  {32'd0, hi_q},  64'd0);
        check("clr_lo",  {32'd0, lo_q},  64'd0);
        check("clr_mar", {32'd0, mar_q}, 64'd0);
        check("clr_z",   z_q,            64'd0);
        rout = 16'hFFFF;
        #1 check("clr_gpr", {32'd0, bus_out}, 64'd0);
        idle(); MDRout = 1;
        #1 check("clr_mdr", {32'd0, bus_out}, 64'd0);
        idle(); InPortOut = 1;
        #1 check("clr_inport", {32'd0, bus_out}, 64'd0);
        idle();
        // Y cleared: 0 + 5 lands in Z
        mdr_load(32'd5);
        MDRout = 1; opcode = OP_ADD; Zin = 1; tick();
        check("clr_y", z_q, 64'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_cpu_datapath
`default_nettype wire
